// File: rtl/alu_pipe_pkg.sv
// Shared opcode and FSM state encodings for the registered ALU pipeline stage.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_LSL  = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_LSR  = 4'b0011,
    OP_ORR  = 4'b0100,
    OP_NOR  = 4'b0101,
    OP_AND  = 4'b0110,
    OP_CBZ  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_EOR  = 4'b1001,
    OP_SUB  = 4'b1010,
    OP_NAND = 4'b1100,
    OP_MOV  = 4'b1101
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_pipe_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle for WIDTH cycles,
// low WIDTH bits of A*B presented with o_done for one cycle.
module alu_pipe_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(WIDTH));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_a    <= i_a;
      r_b    <= i_b;
      r_acc  <= '0;
    end else if (r_busy) begin
      if (w_last) begin
        r_busy <= 1'b0;
      end else begin
        if (r_b[0]) r_acc <= r_acc + r_a;
        r_a   <= r_a << 1;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_busy && w_last;
  assign o_result = r_acc;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU stage with valid/ready handshake and N/Z/C/V/illegal flags.
// Define ALU_PIPE_MUL_EN to build the iterative multiplier for opcode 1000.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             carry_flag,
  output logic             overflow,
  output logic             illegal_op
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_v;
  logic             r_ill;

  state_t           w_state;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_busy;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_ill;
  logic [SHAMT_W-1:0] w_shamt;

`ifdef ALU_PIPE_MUL_EN
  state_t           r_state;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_res;

  assign w_state  = r_state;
  assign w_is_mul = (alu_control == OP_MUL);

  alu_pipe_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (w_accept && w_is_mul),
    .i_a      (data1),
    .i_b      (data2),
    .o_busy   (w_mul_busy),
    .o_done   (w_mul_done),
    .o_result (w_mul_res)
  );
`else
  assign w_state    = ST_IDLE;
  assign w_is_mul   = 1'b0;
  assign w_mul_busy = 1'b0;
`endif

  assign in_ready = (w_state == ST_IDLE) && !w_mul_busy && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  assign w_add   = {1'b0, data1} + {1'b0, data2};
  assign w_sub   = {1'b0, data1} - {1'b0, data2};
  assign w_shamt = data2[SHAMT_W-1:0];

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (op_t'(alu_control))
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (data1[WIDTH-1] == data2[WIDTH-1]) && (w_add[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = ~w_sub[WIDTH];
        w_v   = (data1[WIDTH-1] != data2[WIDTH-1]) && (w_sub[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_CBZ,
      OP_MOV:  w_res = data2;
      OP_AND:  w_res = data1 & data2;
      OP_ORR:  w_res = data1 | data2;
      OP_EOR:  w_res = data1 ^ data2;
      OP_NOR:  w_res = ~(data1 | data2);
      OP_NAND: w_res = ~(data1 & data2);
      OP_LSL:  w_res = data1 << w_shamt;
      OP_LSR:  w_res = data1 >> w_shamt;
      default: w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_ill       <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      r_state     <= ST_IDLE;
`endif
    end else begin
      // A new load in the same cycle overrides the drain clear below.
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_accept && !w_is_mul) begin
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_z         <= (w_res == '0);
        r_n         <= w_res[WIDTH-1];
        r_c         <= w_c;
        r_v         <= w_v;
        r_ill       <= w_ill;
      end
`ifdef ALU_PIPE_MUL_EN
      case (r_state)
        ST_IDLE: if (w_accept && w_is_mul) r_state <= ST_MUL;
        ST_MUL: begin
          if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_mul_res;
            r_z         <= (w_mul_res == '0);
            r_n         <= w_mul_res[WIDTH-1];
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_ill       <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
`endif
    end
  end

  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign zero_flag  = r_z;
  assign neg_flag   = r_n;
  assign carry_flag = r_c;
  assign overflow   = r_v;
  assign illegal_op = r_ill;

endmodule
